spi_frame_ctrl: RTL and testbench

Frame-level controller that sits behind the SPI byte receiver. It consumes the receiver's parallel byte and byte-ready level, and frames transactions with CS. It decodes a command/address/data protocol and drives a simple register-file write/read port. It handles burst address increment, an inter-byte watchdog, and error/abort on malformed frames.

---
 rtl/spi_frame_pkg.sv | 10 +
 rtl/spi_frame_ctrl_if.sv | 22 ++
 rtl/spi_byte_strobe.sv | 15 +
 rtl/spi_frame_ctrl.sv | 151 +++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame controller.
package spi_frame_pkg;
  localparam int         ADDR_W = 8;
  localparam logic [7:0] CMD_WR = 8'h5A;
  localparam logic [7:0] CMD_RD = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_ERR
  } state_t;
endpackage

// File: rtl/spi_frame_ctrl_if.sv
// Byte-receiver and register-port signals of the frame controller.
interface spi_frame_ctrl_if;
  import spi_frame_pkg::*;

  logic              CS;
  logic [7:0]        RxByte;
  logic              RxValid;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [7:0]        WrData;
  logic              RdEn;
  logic [ADDR_W-1:0] RdAddr;
  logic              Busy;
  logic              Err;
  logic              FrameDone;

  // slave: the frame controller; master: the receiver / register side driving it
  modport slave (input CS, RxByte, RxValid,
                 output WrEn, WrAddr, WrData, RdEn, RdAddr, Busy, Err, FrameDone);
  modport master (output CS, RxByte, RxValid,
                  input WrEn, WrAddr, WrData, RdEn, RdAddr, Busy, Err, FrameDone);
endinterface

// File: rtl/spi_byte_strobe.sv
// Turns the receiver's byte-ready level into a single-cycle byte event.
module spi_byte_strobe (
  input  logic CLK,
  input  logic RST,
  input  logic valid,
  output logic evt
);
  logic prev;

  always_ff @(posedge CLK or posedge RST)
    if (RST) prev <= 1'b0;
    else     prev <= valid;

  assign evt = valid & ~prev;
endmodule

// File: rtl/spi_frame_ctrl.sv
// Command/address/data frame decoder driving a register-file port.
// Define SPI_FRAME_AUTOINC_EN for burst mode; otherwise one data access per frame.
module spi_frame_ctrl #(
  parameter int         TIMEOUT = 1023,
  parameter logic [7:0] CMD_WR  = spi_frame_pkg::CMD_WR,
  parameter logic [7:0] CMD_RD  = spi_frame_pkg::CMD_RD
) (
  input logic             CLK,
  input logic             RST,
  spi_frame_ctrl_if.slave bus
);
  import spi_frame_pkg::*;

  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              wr_flag, wr_flag_n;
  logic [WDW-1:0]    wdog, wdog_n;
  logic              evt, active;
  logic              wr_en_n, rd_en_n, err_n, done_n;
  logic [ADDR_W-1:0] wr_addr_n, rd_addr_n;
  logic [7:0]        wr_data_n;
`ifndef SPI_FRAME_AUTOINC_EN
  logic              data_seen, data_seen_n;
`endif

  spi_byte_strobe u_strobe (.CLK(CLK), .RST(RST), .valid(bus.RxValid), .evt(evt));

  assign active = (state == S_CMD) || (state == S_ADDR) ||
                  (state == S_WDATA) || (state == S_RDATA);

  always_comb begin
    state_n   = state;
    addr_n    = addr;
    wr_flag_n = wr_flag;
    wdog_n    = wdog;
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    done_n    = 1'b0;
    err_n     = bus.Err;
    wr_addr_n = bus.WrAddr;
    wr_data_n = bus.WrData;
    rd_addr_n = bus.RdAddr;
`ifndef SPI_FRAME_AUTOINC_EN
    data_seen_n = data_seen;
`endif
    if (active) wdog_n = evt ? '0 : wdog + 1'b1;

    if (state == S_IDLE) begin
      if (!bus.CS) begin
        state_n = S_CMD;
        err_n   = 1'b0;
        wdog_n  = '0;
        addr_n  = '0;
      end
    end else if (bus.CS) begin
      // deselect beats any byte arriving in the same cycle
      state_n = S_IDLE;
      if (state == S_WDATA || state == S_RDATA) done_n = 1'b1;
      if (state == S_CMD || state == S_ADDR)    err_n  = 1'b1;
    end else if (evt && active) begin
      case (state)
        S_CMD: begin
          if (bus.RxByte == CMD_WR)      begin state_n = S_ADDR; wr_flag_n = 1'b1; end
          else if (bus.RxByte == CMD_RD) begin state_n = S_ADDR; wr_flag_n = 1'b0; end
          else                           begin state_n = S_ERR;  err_n = 1'b1;     end
        end
        S_ADDR: begin
          addr_n = bus.RxByte;
`ifndef SPI_FRAME_AUTOINC_EN
          data_seen_n = 1'b0;
`endif
          if (wr_flag) state_n = S_WDATA;
          else begin
            state_n   = S_RDATA;
            rd_en_n   = 1'b1;
            rd_addr_n = bus.RxByte;
          end
        end
        S_WDATA: begin
`ifdef SPI_FRAME_AUTOINC_EN
          wr_en_n   = 1'b1;
          wr_addr_n = addr;
          wr_data_n = bus.RxByte;
          addr_n    = addr + 1'b1;
`else
          if (!data_seen) begin
            wr_en_n     = 1'b1;
            wr_addr_n   = addr;
            wr_data_n   = bus.RxByte;
            data_seen_n = 1'b1;
          end else begin
            state_n = S_ERR;
            err_n   = 1'b1;
          end
`endif
        end
        default: begin
`ifdef SPI_FRAME_AUTOINC_EN
          addr_n    = addr + 1'b1;
          rd_en_n   = 1'b1;
          rd_addr_n = addr + 1'b1;
`else
          state_n = S_ERR;
          err_n   = 1'b1;
`endif
        end
      endcase
    end else if (active && wdog == WDW'(TIMEOUT)) begin
      state_n = S_ERR;
      err_n   = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= S_IDLE;
      addr          <= '0;
      wr_flag       <= 1'b0;
      wdog          <= '0;
      bus.WrEn      <= 1'b0;
      bus.WrAddr    <= '0;
      bus.WrData    <= '0;
      bus.RdEn      <= 1'b0;
      bus.RdAddr    <= '0;
      bus.Busy      <= 1'b0;
      bus.Err       <= 1'b0;
      bus.FrameDone <= 1'b0;
`ifndef SPI_FRAME_AUTOINC_EN
      data_seen     <= 1'b0;
`endif
    end else begin
      state         <= state_n;
      addr          <= addr_n;
      wr_flag       <= wr_flag_n;
      wdog          <= wdog_n;
      bus.WrEn      <= wr_en_n;
      bus.WrAddr    <= wr_addr_n;
      bus.WrData    <= wr_data_n;
      bus.RdEn      <= rd_en_n;
      bus.RdAddr    <= rd_addr_n;
      bus.Busy      <= (state_n != S_IDLE);
      bus.Err       <= err_n;
      bus.FrameDone <= done_n;
`ifndef SPI_FRAME_AUTOINC_EN
      data_seen     <= data_seen_n;
`endif
    end
  end
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench: directed protocol cases plus random frames against a byte-index model.
module tb_spi_frame_ctrl;
  localparam int TMO = 20;
`ifdef SPI_FRAME_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  // frame model: position of the byte in the frame decides its meaning
  int         m_idx;
  logic       m_err, m_wr;
  logic [7:0] m_base;

  spi_frame_ctrl_if bus ();
  spi_frame_ctrl #(.TIMEOUT(TMO)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  function automatic logic [31:0] pack(logic w, logic r, logic [7:0] a, logic [7:0] d);
    return {14'b0, w, r, a, d};
  endfunction

  function automatic logic [31:0] obs();
    logic [7:0] a;
    a = bus.WrEn ? bus.WrAddr : (bus.RdEn ? bus.RdAddr : 8'h00);
    return pack(bus.WrEn, bus.RdEn, a, bus.WrEn ? bus.WrData : 8'h00);
  endfunction

  function automatic logic [31:0] rst_vals();
    return {3'b0, bus.WrEn, bus.RdEn, bus.Busy, bus.Err, bus.FrameDone,
            bus.WrAddr, bus.WrData, bus.RdAddr};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b, output logic [31:0] e);
    int k;
    e = '0;
    if (!m_err) begin
      if (m_idx == 0) begin
        if (b == 8'h5A)      m_wr = 1'b1;
        else if (b == 8'hA5) m_wr = 1'b0;
        else                 m_err = 1'b1;
      end else if (m_idx == 1) begin
        m_base = b;
        if (!m_wr) e = pack(1'b0, 1'b1, b, 8'h00);
      end else begin
        k = m_idx - 2;
        if (m_wr && (AUTOINC || k == 0)) e = pack(1'b1, 1'b0, m_base + 8'(k), b);
        else if (!m_wr && AUTOINC)       e = pack(1'b0, 1'b1, m_base + 8'(k + 1), 8'h00);
        else                             m_err = 1'b1;
      end
    end
    m_idx++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int h, input int g);
    logic [31:0] e;
    model_byte(b, e);
    bus.RxByte  = b;
    bus.RxValid = 1'b1;
    tick();
    check("strobe", obs(), e);
    for (int i = 1; i < h; i++) begin tick(); check("hold_no_strobe", obs(), '0); end
    bus.RxValid = 1'b0;
    for (int i = 0; i < g; i++) begin tick(); check("gap_no_strobe", obs(), '0); end
  endtask

  task automatic frame_start();
    m_idx = 0;
    m_err = 1'b0;
    bus.CS = 1'b0;
    tick();
    check("start_busy_err", {30'b0, bus.Busy, bus.Err}, 32'h2);
  endtask

  task automatic frame_end();
    logic done_e, err_e;
    done_e = !m_err && (m_idx >= 2);
    err_e  = m_err || (m_idx < 2);
    bus.CS = 1'b1;
    tick();
    check("end_done_err_busy", {29'b0, bus.FrameDone, bus.Err, bus.Busy},
          {29'b0, done_e, err_e, 1'b0});
    tick();
    check("done_is_pulse", {31'b0, bus.FrameDone}, 32'h0);
  endtask

  initial begin
    RST = 1'b1;
    bus.CS = 1'b1;
    bus.RxValid = 1'b0;
    bus.RxByte = 8'h00;
    m_idx = 0; m_err = 1'b0; m_wr = 1'b0; m_base = 8'h00;
    #1;
    check("reset_values", rst_vals(), '0);
    repeat (2) tick();
    RST = 1'b0;
    tick();
    check("idle_after_reset", rst_vals(), '0);

    // write burst; AB held high four cycles must strobe once
    frame_start();
    send_byte(8'h5A, 1, 1); send_byte(8'h10, 2, 1);
    send_byte(8'hAB, 4, 2); send_byte(8'hCD, 1, 2);
    frame_end();

    // read with address wrap FF -> 00
    frame_start();
    send_byte(8'hA5, 1, 1); send_byte(8'hFF, 1, 1); send_byte(8'h00, 2, 1);
    frame_end();

    // bad command, then a clean frame clears Err at frame start
    frame_start();
    send_byte(8'h33, 1, 2); send_byte(8'h10, 1, 1);
    frame_end();
    frame_start();
    send_byte(8'h5A, 1, 1); send_byte(8'h20, 1, 1); send_byte(8'h77, 1, 1);
    frame_end();

    // watchdog: counter restarts at the byte event, Err registers the cycle after it reads TIMEOUT
    frame_start();
    begin
      logic [31:0] e;
      model_byte(8'h5A, e);
      bus.RxByte = 8'h5A; bus.RxValid = 1'b1;
      tick();
      check("tmo_cmd_no_strobe", obs(), e);
      bus.RxValid = 1'b0;
      for (int k = 1; k <= TMO + 1; k++) begin
        tick();
        if (k == TMO)     check("tmo_err_before", {31'b0, bus.Err}, 32'h0);
        if (k == TMO + 1) check("tmo_err_at", {31'b0, bus.Err}, 32'h1);
      end
      m_err = 1'b1;
    end
    send_byte(8'h10, 1, 1); send_byte(8'h99, 1, 1);
    frame_end();

    // CS rising together with an RxValid edge: byte dropped, frame still ends cleanly
    frame_start();
    send_byte(8'h5A, 1, 1); send_byte(8'h40, 1, 1);
    bus.CS = 1'b1; bus.RxByte = 8'hEE; bus.RxValid = 1'b1;
    tick();
    check("cs_wins_strobe", obs(), '0);
    check("cs_wins_done", {30'b0, bus.FrameDone, bus.Err}, 32'h2);
    bus.RxValid = 1'b0;
    tick();

    // reset in the middle of a burst
    frame_start();
    send_byte(8'h5A, 1, 1); send_byte(8'h60, 1, 1); send_byte(8'h11, 1, 1);
    bus.RxByte = 8'h22; bus.RxValid = 1'b1; RST = 1'b1;
    #1;
    check("rst_mid_async", rst_vals(), '0);
    tick();
    check("rst_mid_held", rst_vals(), '0);
    bus.RxValid = 1'b0;
    RST = 1'b0;
    m_idx = 0; m_err = 1'b0;
    tick();
    check("rst_mid_rebusy", {31'b0, bus.Busy}, 32'h1);
    send_byte(8'h33, 1, 1);
    frame_end();

    // random frames
    for (int f = 0; f < 40; f++) begin
      int n;
      logic [7:0] c;
      case ($urandom_range(4, 0))
        0:       c = 8'($urandom);
        1, 2:    c = 8'h5A;
        default: c = 8'hA5;
      endcase
      n = $urandom_range(5, 0);
      frame_start();
      if (n > 0) send_byte(c, $urandom_range(3, 1), $urandom_range(3, 1));
      for (int i = 1; i < n; i++)
        send_byte(8'($urandom), $urandom_range(3, 1), $urandom_range(3, 1));
      frame_end();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
